// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-wide instruction
// memory write port, little-endian, one byte per cycle, while holding the core.
module imem_loader #(
   parameter int SIZE  = 64,
   parameter int CNT_W = $clog2(SIZE/4)+1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [63:0]      base_adr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_word,
   input  logic             in_last,
   output logic             mem_we,
   output logic [63:0]      mem_adr,
   output logic [7:0]       mem_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] words_loaded
);

   // Highest byte address at which a whole word still fits in the memory.
   localparam logic [63:0] LAST_WORD_ADR = 64'(SIZE - 4);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [63:0]      ptr_q, ptr_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [31:0]      word_q, word_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] words_q, words_d;

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= 64'd0;
         byte_idx_q <= 2'd0;
         word_q     <= 32'd0;
         last_q     <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         last_q     <= last_d;
         words_q    <= words_d;
      end
   end

   // Next-state logic: session start/validation, word accept, byte sequencing.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      last_d     = last_q;
      words_d    = words_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               words_d = '0;
               // A misaligned base or one with no room for a word aborts at once.
               if ((base_adr[1:0] != 2'b00) || (base_adr > LAST_WORD_ADR)) begin
                  state_d = S_ERR;
               end else begin
                  ptr_d   = base_adr;
                  state_d = S_WAIT;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_WAIT: begin
            if (in_valid) begin
               if (ptr_q <= LAST_WORD_ADR) begin
                  word_d     = in_word;
                  last_d     = in_last;
                  byte_idx_d = 2'd0;
                  state_d    = S_WRITE;
               end else begin
                  // Memory full and the source still offers data: overflow.
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WRITE: begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
               ptr_d   = ptr_q + 64'd4;
               words_d = words_q + CNT_W'(1);
               state_d = last_q ? S_DONE : S_WAIT;
            end else begin
               state_d = S_WRITE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded purely from registered state; address/data forced to 0 when idle.
   always_comb begin
      in_ready     = 1'b0;
      mem_we       = 1'b0;
      mem_adr      = 64'd0;
      mem_data     = 8'd0;
      busy         = (state_q == S_WAIT) || (state_q == S_WRITE);
      done         = (state_q == S_DONE);
      err          = (state_q == S_ERR);
      words_loaded = words_q;
      if (state_q == S_WAIT) begin
         in_ready = (ptr_q <= LAST_WORD_ADR);
      end else begin
         in_ready = 1'b0;
      end
      if (state_q == S_WRITE) begin
         mem_we   = 1'b1;
         mem_adr  = ptr_q + {62'd0, byte_idx_q};
         mem_data = word_q[{byte_idx_q, 3'b000} +: 8];
      end else begin
         mem_we   = 1'b0;
         mem_adr  = 64'd0;
         mem_data = 8'd0;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected byte writes,
// a monitor pops and compares every presented mem_we.
module tb_imem_loader;

   localparam int SIZE  = 64;
   localparam int CNT_W = $clog2(SIZE/4)+1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [63:0]      base_adr = 64'd0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_word = 32'd0;
   logic             in_last = 1'b0;
   logic             mem_we;
   logic [63:0]      mem_adr;
   logic [7:0]       mem_data;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] words_loaded;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          mon_en = 1'b0;
   logic [63:0] exp_ptr = 64'd0;
   logic [71:0] exp_q[$];
   logic [7:0]  mem_img [0:SIZE-1];

   imem_loader #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
      .mem_we(mem_we), .mem_adr(mem_adr), .mem_data(mem_data),
      .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares each byte write against the scoreboard queue.
   initial forever begin
      logic [71:0] e;
      @(negedge clk);
      if (mon_en) begin
         if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write_adr", mem_adr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("write_adr", mem_adr, e[71:8]);
               check("write_data", {56'd0, mem_data}, {56'd0, e[7:0]});
            end
            if (mem_adr < 64'(SIZE)) begin
               if (rst_n) mem_img[mem_adr[5:0]] = mem_data;
            end else begin
               check("write_in_range", mem_adr, 64'(SIZE - 1));
            end
         end else begin
            check("idle_adr_data_zero", {mem_adr, mem_data}, 72'd0);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n = n + 1;
      end
      if (in_ready !== 1'b1) check("ready_timeout", 64'(n), 64'd0);
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (done !== 1'b1 && err !== 1'b1 && n < 60) begin
         tick();
         n = n + 1;
      end
      if (done !== 1'b1 && err !== 1'b1) check("end_timeout", 64'(n), 64'd0);
   endtask

   task automatic do_start(input logic [63:0] b);
      start = 1'b1;
      base_adr = b;
      tick();
      start = 1'b0;
      base_adr = 64'd0;
   endtask

   // Presents a word, waits for acceptance, and records its four expected bytes.
   task automatic send_word(input logic [31:0] w, input logic l);
      in_valid = 1'b1;
      in_word  = w;
      in_last  = l;
      wait_ready();
      acc_cyc = cyc;
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back({exp_ptr + 64'(b), w[8*b +: 8]});
      end
      exp_ptr = exp_ptr + 64'd4;
      tick();
   endtask

   initial begin
      logic [31:0] prog [0:3];
      logic [7:0]  img [0:15];
      int          t0;
      prog[0] = 32'h0000_2103; prog[1] = 32'h0021_00B3;
      prog[2] = 32'h0010_2623; prog[3] = 32'h00C0_2183;
      img[0]  = 8'h03; img[1]  = 8'h21; img[2]  = 8'h00; img[3]  = 8'h00;
      img[4]  = 8'hB3; img[5]  = 8'h00; img[6]  = 8'h21; img[7]  = 8'h00;
      img[8]  = 8'h23; img[9]  = 8'h26; img[10] = 8'h10; img[11] = 8'h00;
      img[12] = 8'h83; img[13] = 8'h21; img[14] = 8'hC0; img[15] = 8'h00;
      for (int i = 0; i < SIZE; i++) mem_img[i] = 8'h00;

      // Reset state
      tick(); tick();
      check("reset_outputs", {56'd0, in_ready, mem_we, busy, done, err, 3'd0},
            64'd0);
      check("reset_words", 64'(words_loaded), 64'd0);
      check("reset_adr", mem_adr, 64'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      tick();

      // 1: four words, in_valid held high, base 0
      do_start(64'd0);
      check("t1_busy_wait", {63'd0, busy}, 64'd1);
      exp_ptr = 64'd0;
      t0 = 0;
      for (int i = 0; i < 4; i++) begin
         send_word(prog[i], (i == 3));
         if (i == 0) t0 = acc_cyc;
      end
      in_valid = 1'b0;
      wait_end();
      check("t1_done", {62'd0, done, err}, 64'd2);
      check("t1_latency", 64'(cyc - t0), 64'd20);
      check("t1_words", 64'(words_loaded), 64'd4);
      for (int i = 0; i < 16; i++) check("t1_image", {56'd0, mem_img[i]}, {56'd0, img[i]});

      // 2: same stream with 3-cycle gaps between words
      do_start(64'd0);
      check("t2_words_cleared", 64'(words_loaded), 64'd0);
      exp_ptr = 64'd0;
      for (int i = 0; i < 4; i++) begin
         send_word(prog[i], (i == 3));
         in_valid = 1'b0;
         if (i < 3) begin
            wait_ready();
            for (int g = 0; g < 3; g++) begin
               check("t2_busy_gap", {63'd0, busy}, 64'd1);
               tick();
            end
         end
      end
      wait_end();
      check("t2_done", {62'd0, done, err}, 64'd2);
      check("t2_words", 64'(words_loaded), 64'd4);
      for (int i = 0; i < 16; i++) check("t2_image", {56'd0, mem_img[i]}, {56'd0, img[i]});

      // 4: misaligned base from DONE
      do_start(64'd2);
      check("t4_flags", {61'd0, busy, done, err}, 64'd1);
      check("t4_words", 64'(words_loaded), 64'd0);
      for (int g = 0; g < 3; g++) begin
         check("t4_no_ready", {62'd0, in_ready, err}, 64'd1);
         tick();
      end

      // 3: base 56, overflow on the third word
      do_start(64'd56);
      check("t3_busy", {62'd0, busy, err}, 64'd2);
      exp_ptr = 64'd56;
      send_word(32'h4433_2211, 1'b0);
      send_word(32'h8877_6655, 1'b0);
      in_word = 32'h1234_5678;
      in_last = 1'b0;
      repeat (4) tick();
      check("t3_full_wait", {62'd0, in_ready, busy}, 64'd1);
      tick();
      check("t3_err", {61'd0, busy, done, err}, 64'd1);
      check("t3_words", 64'(words_loaded), 64'd2);
      in_valid = 1'b0;
      check("t3_image_63", {56'd0, mem_img[63]}, 64'h88);

      // 5: reset while writing byte 2
      do_start(64'd0);
      exp_ptr = 64'd0;
      send_word(32'h1122_3344, 1'b1);
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_after_reset", {60'd0, mem_we, busy, done, err}, 64'd0);
      check("t5_words", 64'(words_loaded), 64'd0);
      check("t5_byte3_pending", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
      check("t5_mem0", {56'd0, mem_img[0]}, 64'h44);
      check("t5_mem1", {56'd0, mem_img[1]}, 64'h33);
      tick();

      // 6: start ignored during WRITE, then restart from DONE at base 16
      do_start(64'd0);
      exp_ptr = 64'd0;
      send_word(32'hCAFE_F00D, 1'b1);
      in_valid = 1'b0;
      tick();
      start = 1'b1;
      base_adr = 64'd32;
      tick();
      start = 1'b0;
      base_adr = 64'd0;
      wait_end();
      check("t6_done_first", {62'd0, done, err}, 64'd2);
      check("t6_words_first", 64'(words_loaded), 64'd1);
      do_start(64'd16);
      check("t6_restart", {61'd0, busy, done, err}, 64'd4);
      exp_ptr = 64'd16;
      send_word(32'hDEAD_BEEF, 1'b1);
      in_valid = 1'b0;
      wait_end();
      check("t6_done", {62'd0, done, err}, 64'd2);
      check("t6_words", 64'(words_loaded), 64'd1);
      check("t6_image", {32'd0, mem_img[19], mem_img[18], mem_img[17], mem_img[16]},
            64'hDEAD_BEEF);
      tick();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
      $fatal(1, "watchdog");
   end

endmodule
